// File: rtl/puf_rng_packer.sv
// Packs PUF RNG nibbles into WORD_W-bit words and queues them for the entropy consumer.
// Optional repetition-count health test is compiled in with `define PUF_RNG_RCT_EN.
module puf_rng_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_CUTOFF = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [3:0]                    rng4bit_i,
    input  logic                          rng4bit_done_i,
    input  logic                          rng_mode_i,
    output logic                          es_rng_req_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WORD_W-1:0]             out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
    output logic                          ovf_o,
    output logic                          rct_fail_o
);

    localparam int NIBS = WORD_W / 4;
    localparam int CW   = $clog2(NIBS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    if ((WORD_W % 4) != 0 || WORD_W < 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RCT_CUTOFF < 2) begin : g_param_check
        $error("puf_rng_packer: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, STALL} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [WORD_W-1:0] word, hold, completed, push_data;
    logic              hold_load;
    logic              go, nib_in, rct_hit;
    logic              push, pop, full;
    logic              ovf_set, ovf, req;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     lvl, lvl_next;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];

    assign go          = enable_i & rng_mode_i;
    assign nib_in      = go & (state == COLLECT) & rng4bit_done_i;
    assign full        = (lvl == LW'(FIFO_DEPTH));
    assign out_valid_o = (lvl != '0);
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        completed = word;
        completed[4*cnt +: 4] = rng4bit_i;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push       = 1'b0;
        push_data  = completed;
        hold_load  = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_next = COLLECT;
            end
            COLLECT: begin
                if (!go) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (nib_in) begin
                    if (rct_hit) begin
                        cnt_next = '0;
                    end else if (cnt == CW'(NIBS - 1)) begin
                        cnt_next = '0;
                        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            hold_load  = 1'b1;
                            state_next = STALL;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            STALL: begin
                if (!go) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    ovf_set = rng4bit_done_i;
                    if (!full || pop) begin
                        push       = 1'b1;
                        push_data  = hold;
                        cnt_next   = '0;
                        state_next = COLLECT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign lvl_next = !enable_i ? '0 : lvl + LW'(push) - LW'(pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            req   <= go && (state_next == COLLECT) && (lvl_next != LW'(FIFO_DEPTH));
            if (ovf_set)      ovf <= 1'b1;
            else if (clear_i) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (nib_in && !rct_hit) word <= completed;
        if (hold_load)          hold <= completed;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else if (!enable_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            lvl <= lvl_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so the head is masked while empty.
    assign out_data_o   = out_valid_o ? mem[rd_ptr] : '0;
    assign fifo_lvl_o   = lvl;
    assign es_rng_req_o = req;
    assign ovf_o        = ovf;

`ifdef PUF_RNG_RCT_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    logic [RW-1:0] rep, rep_inc;
    logic [3:0]    last_nib;
    logic          rct_fail;

    // last_nib is only meaningful while rep is non-zero.
    assign rep_inc = (rep != '0 && rng4bit_i == last_nib) ? rep + 1'b1 : RW'(1);
    assign rct_hit = nib_in && (rep_inc == RW'(RCT_CUTOFF));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep      <= '0;
            rct_fail <= 1'b0;
        end else begin
            if (!go || rct_hit) rep <= '0;
            else if (nib_in)    rep <= rep_inc;
            if (rct_hit)        rct_fail <= 1'b1;
            else if (clear_i)   rct_fail <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (nib_in) last_nib <= rng4bit_i;
    end

    assign rct_fail_o = rct_fail;
`else
    assign rct_hit    = 1'b0;
    assign rct_fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_puf_rng_packer.sv
// Bench for puf_rng_packer: table of packing vectors plus hand-written flow-control sequences.
// Popped words are checked against a queue of expected words filled when stimulus is driven.
module tb_puf_rng_packer;

    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int RCT_CUTOFF = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [3:0]        nib = 4'h0;
    logic              done = 1'b0;
    logic              mode = 1'b0;
    logic              ready = 1'b0;
    logic              req, valid, ovf, rct;
    logic [WORD_W-1:0] data;
    logic [2:0]        lvl;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] expq[$];
    logic [31:0] mon_w;

    typedef struct {
        logic [31:0] seq;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    puf_rng_packer #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RCT_CUTOFF(RCT_CUTOFF)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .clear_i       (clear),
        .rng4bit_i     (nib),
        .rng4bit_done_i(done),
        .rng_mode_i    (mode),
        .es_rng_req_o  (req),
        .out_valid_o   (valid),
        .out_ready_i   (ready),
        .out_data_o    (data),
        .fifo_lvl_o    (lvl),
        .ovf_o         (ovf),
        .rct_fail_o    (rct)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] n);
        nib  = n;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    function automatic logic [3:0] gen_nib(input int k, input int j);
        return 4'((j + k) & 15);
    endfunction

    function automatic logic [31:0] word_of(input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[4*j +: 4] = gen_nib(k, j);
        return w;
    endfunction

    task automatic send_word(input int k);
        for (int j = 0; j < 8; j++) strobe(gen_nib(k, j));
    endtask

    // seq lists nibbles in send order, first nibble in the MSBs
    task automatic send_seq(input logic [31:0] s);
        for (int i = 0; i < 8; i++) strobe(s[31-4*i -: 4]);
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        repeat (n) tick();
        ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %h, expected no pop", data);
            end else begin
                mon_w = expq.pop_front();
                chk("pop_data", data, mon_w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{seq: 32'h12345678, exp: 32'h87654321};
        vecs[1] = '{seq: 32'hF0F0F0F0, exp: 32'h0F0F0F0F};
        vecs[2] = '{seq: 32'hDEADBEEF, exp: 32'hFEEBDAED};
        vecs[3] = '{seq: 32'h0123ABCD, exp: 32'hDCBA3210};
        vecs[4] = '{seq: 32'h9999999A, exp: 32'hA9999999};
        vecs[5] = '{seq: 32'hC3C3A5A5, exp: 32'h5A5A3C3C};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data",  data,       32'h0);
        chk("rst_lvl",   32'(lvl),   32'd0);
        chk("rst_req",   32'(req),   32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_rct",   32'(rct),   32'd0);

        enable = 1'b1;
        mode   = 1'b1;
        tick();
        chk("req_collect", 32'(req), 32'd1);

        for (int v = 0; v < 6; v++) begin
            send_seq(vecs[v].seq);
            chk("vec_data", data, vecs[v].exp);
            chk("vec_lvl", 32'(lvl), 32'd1);
            expq.push_back(vecs[v].exp);
            drain(1);
            chk("vec_lvl_after_pop", 32'(lvl), 32'd0);
        end

        // backpressure into STALL, overflow flag and set-over-clear priority
        send_word(1);
        chk("basic_data", data, 32'h87654321);
        chk("basic_lvl", 32'(lvl), 32'd1);
        expq.push_back(word_of(1));
        for (int k = 2; k <= 4; k++) begin
            send_word(k);
            expq.push_back(word_of(k));
        end
        chk("bp_lvl_full", 32'(lvl), 32'd4);
        chk("bp_req_full", 32'(req), 32'd0);
        send_word(5);
        expq.push_back(word_of(5));
        chk("bp_lvl_stall", 32'(lvl), 32'd4);
        chk("bp_ovf_before", 32'(ovf), 32'd0);
        strobe(4'h0);
        chk("bp_ovf_set", 32'(ovf), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("bp_ovf_clear", 32'(ovf), 32'd0);
        clear = 1'b1;
        strobe(4'h0);
        clear = 1'b0;
        chk("bp_ovf_set_wins", 32'(ovf), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_lvl_release", 32'(lvl), 32'd4);
        drain(4);
        chk("bp_lvl_drained", 32'(lvl), 32'd0);
        chk("bp_req_resume", 32'(req), 32'd1);

        // enable flush keeps sticky flags
        for (int k = 6; k <= 8; k++) begin
            send_word(k);
            expq.push_back(word_of(k));
        end
        chk("fl_lvl_before", 32'(lvl), 32'd3);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        chk("fl_lvl", 32'(lvl), 32'd0);
        chk("fl_valid", 32'(valid), 32'd0);
        chk("fl_req", 32'(req), 32'd0);
        chk("fl_ovf_kept", 32'(ovf), 32'd1);
        expq.delete();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("fl_ovf_cleared", 32'(ovf), 32'd0);

        // full FIFO with simultaneous push and pop
        for (int k = 1; k <= 4; k++) begin
            send_word(k);
            expq.push_back(word_of(k));
        end
        chk("sim_lvl_full", 32'(lvl), 32'd4);
        for (int j = 0; j < 7; j++) strobe(gen_nib(5, j));
        expq.push_back(word_of(5));
        ready = 1'b1;
        strobe(gen_nib(5, 7));
        ready = 1'b0;
        chk("sim_lvl", 32'(lvl), 32'd4);
        chk("sim_ovf", 32'(ovf), 32'd0);
        strobe(4'h3);
        chk("sim_no_stall", 32'(ovf), 32'd0);
        drain(4);
        chk("sim_lvl_drained", 32'(lvl), 32'd0);

        // mode drop mid-word discards the partial word
        strobe(4'hE);
        strobe(4'hD);
        strobe(4'hC);
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        send_word(0);
        chk("md_data", data, 32'h76543210);
        chk("md_lvl", 32'(lvl), 32'd1);
        expq.push_back(32'h76543210);
        drain(1);

        // repetition-count test stimulus
        for (int i = 0; i < 8; i++) strobe(4'hA);
`ifdef PUF_RNG_RCT_EN
        chk("rct_fail", 32'(rct), 32'd1);
        chk("rct_no_push", 32'(lvl), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("rct_clear", 32'(rct), 32'd0);
        send_word(1);
        chk("rct_next_word", data, 32'h87654321);
        expq.push_back(32'h87654321);
        drain(1);
`else
        chk("rct_word", data, 32'hAAAAAAAA);
        chk("rct_lvl", 32'(lvl), 32'd1);
        chk("rct_flag", 32'(rct), 32'd0);
        expq.push_back(32'hAAAAAAAA);
        drain(1);
`endif
        tick();
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
